// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch, load/store and memory-side handshake signals around mem_arbiter.
// The slave modport is the arbiter's view; master is the core/memory environment's view.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) ();
  logic                  imem_req;
  logic [ADDR_W-1:0]     imem_addr;
  logic                  imem_gnt;
  logic                  imem_valid;
  logic [DATA_W-1:0]     imem_rdata;

  logic                  dmem_req;
  logic                  dmem_we;
  logic [ADDR_W-1:0]     dmem_addr;
  logic [DATA_W-1:0]     dmem_wdata;
  logic [DATA_W/8-1:0]   dmem_wmask;
  logic                  dmem_gnt;
  logic                  dmem_valid;
  logic [DATA_W-1:0]     dmem_rdata;

  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_wmask;
  logic                  mem_ready;
  logic                  mem_rvalid;
  logic [DATA_W-1:0]     mem_rdata;

  logic                  stall;
  logic                  bus_err;

  modport slave (
    input  imem_req, imem_addr,
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wmask,
    input  mem_ready, mem_rvalid, mem_rdata,
    output imem_gnt, imem_valid, imem_rdata,
    output dmem_gnt, dmem_valid, dmem_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
    output stall, bus_err
  );

  modport master (
    output imem_req, imem_addr,
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wmask,
    output mem_ready, mem_rvalid, mem_rdata,
    input  imem_gnt, imem_valid, imem_rdata,
    input  dmem_gnt, dmem_valid, dmem_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
    input  stall, bus_err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter sharing one variable-latency memory between fetch and load/store.
// Define MEM_ARB_RR_EN for round-robin on contested grants; default is dmem-over-imem priority.
module mem_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 256
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus
);
  localparam int unsigned MaskW = DATA_W / 8;
  localparam logic OwnImem = 1'b0;
  localparam logic OwnDmem = 1'b1;
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

  state_e              state_q, state_d;
  logic                owner_q, owner_d;
  logic [15:0]         cnt_q, cnt_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [MaskW-1:0]    mem_wmask_q, mem_wmask_d;
  logic                imem_gnt_q, imem_gnt_d;
  logic                dmem_gnt_q, dmem_gnt_d;
  logic                imem_valid_q, imem_valid_d;
  logic                dmem_valid_q, dmem_valid_d;
  logic [DATA_W-1:0]   imem_rdata_q, imem_rdata_d;
  logic [DATA_W-1:0]   dmem_rdata_q, dmem_rdata_d;
  logic                bus_err_q, bus_err_d;

  logic                prefer_dmem;
  logic                timed_out;
  logic                resp_go;
  logic                abort;
  logic [DATA_W-1:0]   resp_data;

`ifdef MEM_ARB_RR_EN
  // owner_q still holds the previous owner while idle, so it doubles as the round-robin pointer.
  assign prefer_dmem = (owner_q == OwnImem);
`else
  assign prefer_dmem = 1'b1;
`endif

  assign timed_out = (cnt_q == TimeoutLast);

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    cnt_d        = cnt_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wmask_d  = mem_wmask_q;
    imem_gnt_d   = 1'b0;
    dmem_gnt_d   = 1'b0;
    imem_valid_d = 1'b0;
    dmem_valid_d = 1'b0;
    imem_rdata_d = '0;
    dmem_rdata_d = '0;
    bus_err_d    = bus_err_q;
    resp_go      = 1'b0;
    abort        = 1'b0;
    resp_data    = '0;

    unique case (state_q)
      StIdle: begin
        if (bus.dmem_req && (!bus.imem_req || prefer_dmem)) begin
          owner_d     = OwnDmem;
          dmem_gnt_d  = 1'b1;
          mem_req_d   = 1'b1;
          mem_we_d    = bus.dmem_we;
          mem_addr_d  = bus.dmem_addr;
          mem_wdata_d = bus.dmem_wdata;
          mem_wmask_d = bus.dmem_wmask;
          cnt_d       = '0;
          state_d     = StReq;
        end else if (bus.imem_req) begin
          owner_d     = OwnImem;
          imem_gnt_d  = 1'b1;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = bus.imem_addr;
          mem_wdata_d = '0;
          mem_wmask_d = '0;
          cnt_d       = '0;
          state_d     = StReq;
        end
      end
      StReq: begin
        cnt_d = cnt_q + 16'd1;
        if (bus.mem_ready && bus.mem_rvalid) begin
          resp_go   = 1'b1;
          resp_data = bus.mem_rdata;
        end else if (timed_out) begin
          abort = 1'b1;
        end else if (bus.mem_ready) begin
          mem_req_d = 1'b0;
          state_d   = StWait;
        end
      end
      StWait: begin
        cnt_d = cnt_q + 16'd1;
        // A response in the timeout cycle still wins over the abort.
        if (bus.mem_rvalid) begin
          resp_go   = 1'b1;
          resp_data = bus.mem_rdata;
        end else if (timed_out) begin
          abort = 1'b1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (resp_go || abort) begin
      state_d   = StResp;
      mem_req_d = 1'b0;
      if (owner_q == OwnDmem) begin
        dmem_valid_d = 1'b1;
        dmem_rdata_d = mem_we_q ? '0 : resp_data;
      end else begin
        imem_valid_d = 1'b1;
        imem_rdata_d = resp_data;
      end
    end
    if (abort) begin
      bus_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      owner_q      <= OwnImem;
      cnt_q        <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wmask_q  <= '0;
      imem_gnt_q   <= 1'b0;
      dmem_gnt_q   <= 1'b0;
      imem_valid_q <= 1'b0;
      dmem_valid_q <= 1'b0;
      imem_rdata_q <= '0;
      dmem_rdata_q <= '0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      cnt_q        <= cnt_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wmask_q  <= mem_wmask_d;
      imem_gnt_q   <= imem_gnt_d;
      dmem_gnt_q   <= dmem_gnt_d;
      imem_valid_q <= imem_valid_d;
      dmem_valid_q <= dmem_valid_d;
      imem_rdata_q <= imem_rdata_d;
      dmem_rdata_q <= dmem_rdata_d;
      bus_err_q    <= bus_err_d;
    end
  end

  assign bus.imem_gnt   = imem_gnt_q;
  assign bus.dmem_gnt   = dmem_gnt_q;
  assign bus.imem_valid = imem_valid_q;
  assign bus.dmem_valid = dmem_valid_q;
  assign bus.imem_rdata = imem_rdata_q;
  assign bus.dmem_rdata = dmem_rdata_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.mem_wmask  = mem_wmask_q;
  assign bus.bus_err    = bus_err_q;
  assign bus.stall      = bus.imem_req | bus.dmem_req | (state_q == StReq) | (state_q == StWait);

endmodule
